interface_botoes: RTL and testbench

Input-conditioning stage directly upstream of the game core; produces its botoes_encoded, right_arrow_pressed, left_arrow_pressed and enter_pressed inputs.
- Synchronises and debounces 12 raw active-low note buttons and 3 raw active-low navigation keys.
- Encodes the note buttons into one latched 4-bit code.
- Converts each navigation press into a single-cycle active-low pulse, matching the core's active-low navigation inputs.

---
 rtl/interface_botoes_pkg.sv | 51 +++++
 rtl/interface_botoes_debouncer_botao.sv | 73 +++++++
 rtl/interface_botoes.sv | 170 +++++++++++++++++
 tb/tb_interface_botoes.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/interface_botoes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : interface_botoes_pkg
// Brief    : Shared types, constants and cycle-count helpers for the button
//            input-conditioning stage (note FSM states, note count, code
//            width, debounce/repeat cycle counts, note priority encoder).
// Revision : 1.0 - initial release
// ============================================================================
package interface_botoes_pkg;

  localparam int NOTAS    = 12;
  localparam int CODIGO_W = 4;
  localparam int NAV      = 3;

  // Note FSM states; code 3 is never entered on purpose
  typedef enum logic [1:0] {
    OCIOSO        = 2'd0,
    TRAVADO       = 2'd1,
    ESPERA_SOLTAR = 2'd2
  } estado_t;

  // Stable time in clock cycles, never below one cycle
  function automatic int unsigned ciclos_debounce(input int unsigned clock_freq,
                                                  input int unsigned debounce_ms);
    int unsigned c;
    c = (clock_freq / 1000) * debounce_ms;
    if (c < 1) c = 1;
    return c;
  endfunction

  // Auto-repeat period in clock cycles, never below one cycle
  function automatic int unsigned ciclos_repeticao(input int unsigned clock_freq,
                                                   input int unsigned repeat_ms);
    int unsigned c;
    c = (clock_freq / 1000) * repeat_ms;
    if (c < 1) c = 1;
    return c;
  endfunction

  // Lowest pressed note index + 1, or 0 when nothing is pressed
  function automatic logic [CODIGO_W-1:0] codifica_nota(input logic [NOTAS-1:0] pressionadas);
    logic [CODIGO_W-1:0] codigo;
    codigo = '0;
    for (int i = NOTAS - 1; i >= 0; i--) begin
      if (pressionadas[i]) codigo = CODIGO_W'(i + 1);
    end
    return codigo;
  endfunction

endpackage
`default_nettype wire

// File: rtl/interface_botoes_debouncer_botao.sv
`default_nettype none
// ============================================================================
// Module   : debouncer_botao
// Brief    : One active-low input channel: 2-FF synchroniser, stability
//            counter and debounced level. After reset the channel stays
//            "released" until the key has been seen released once, so a key
//            held through reset must be released and pressed again.
// Revision : 1.0 - initial release
// ============================================================================
module debouncer_botao #(
  parameter int unsigned N = 1
) (
  input  logic clock_i,
  input  logic reset_n_i,
  input  logic bruto_n_i,
  output logic nivel_n_o
);

  localparam int unsigned CNT_W = (N < 2) ? 1 : $clog2(N + 1);

  logic             sinc1_q;
  logic             sinc2_q;
  logic             estavel_q;
  logic             estavel_d;
  logic [CNT_W-1:0] cont_q;
  logic [CNT_W-1:0] cont_d;
  logic [1:0]       valido_q;
  logic             armado_q;
  logic             armado_d;

  // Counter advances only while the synchronised sample disagrees with the
  // stable level; the N-th consecutive disagreement adopts the new value
  always_comb begin
    cont_d    = '0;
    estavel_d = estavel_q;
    if (sinc2_q != estavel_q) begin
      if (cont_q == CNT_W'(N - 1)) begin
        estavel_d = sinc2_q;
        cont_d    = '0;
      end else begin
        cont_d = cont_q + CNT_W'(1);
      end
    end
  end

  // Arm once the pipeline carries real samples and the key is seen released
  always_comb begin
    armado_d = armado_q | (valido_q[1] & sinc2_q & estavel_q);
  end

  // Synchroniser, debounce state and arming flag
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      sinc1_q   <= 1'b1;
      sinc2_q   <= 1'b1;
      estavel_q <= 1'b1;
      cont_q    <= '0;
      valido_q  <= 2'b00;
      armado_q  <= 1'b0;
    end else begin
      sinc1_q   <= bruto_n_i;
      sinc2_q   <= sinc1_q;
      estavel_q <= estavel_d;
      cont_q    <= cont_d;
      valido_q  <= {valido_q[0], 1'b1};
      armado_q  <= armado_d;
    end
  end

  assign nivel_n_o = estavel_q | ~armado_q;

endmodule
`default_nettype wire

// File: rtl/interface_botoes.sv
`default_nettype none
// ============================================================================
// Module   : interface_botoes
// Brief    : Input conditioning ahead of the game core. Debounces 12 note
//            buttons and 3 navigation keys, latches one note code with a
//            release-before-next-note FSM and turns each navigation press
//            into a one-cycle active-low pulse.
//            Optional macro AUTO_REPEAT_EN: arrow keys held down re-pulse
//            every REPEAT_MS milliseconds.
// Revision : 1.0 - initial release
// ============================================================================
module interface_botoes
  import interface_botoes_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ  = 50000000,
  parameter int unsigned DEBOUNCE_MS = 10,
  parameter int unsigned REPEAT_MS   = 300
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NOTAS-1:0]    botoes_n,
  input  logic                right_n,
  input  logic                left_n,
  input  logic                enter_n,
  output logic [CODIGO_W-1:0] botoes_encoded,
  output logic                nota_valida,
  output logic                right_arrow_pressed,
  output logic                left_arrow_pressed,
  output logic                enter_pressed,
  output logic [1:0]          db_estado
);

  localparam int unsigned N_DEB    = ciclos_debounce(CLOCK_FREQ, DEBOUNCE_MS);
  localparam int          CANAIS   = NOTAS + NAV;

  logic [CANAIS-1:0]   w_bruto_n;
  logic [CANAIS-1:0]   w_nivel_n;
  logic [NOTAS-1:0]    w_notas;
  logic [NAV-1:0]      w_nav_press;
  logic [CODIGO_W-1:0] w_codigo;
  logic [NAV-1:0]      w_repete;
  logic [NAV-1:0]      pulso_d;
  logic [NAV-1:0]      pulso_q;
  logic [NAV-1:0]      nav_ant_q;

  estado_t             estado_q;
  logic [CODIGO_W-1:0] codigo_q;
  logic [CODIGO_W-1:0] idx_q;
  logic                valida_q;

  // Channel order: notes in the low bits, then right, left, enter
  assign w_bruto_n = {enter_n, left_n, right_n, botoes_n};

  for (genvar c = 0; c < CANAIS; c++) begin : g_canal
    debouncer_botao #(
      .N(N_DEB)
    ) u_debouncer (
      .clock_i  (clock),
      .reset_n_i(reset),
      .bruto_n_i(w_bruto_n[c]),
      .nivel_n_o(w_nivel_n[c])
    );
  end

  assign w_notas     = ~w_nivel_n[NOTAS-1:0];
  assign w_nav_press = ~w_nivel_n[CANAIS-1:NOTAS];
  assign w_codigo    = codifica_nota(w_notas);

`ifdef AUTO_REPEAT_EN
  localparam int unsigned N_REP = ciclos_repeticao(CLOCK_FREQ, REPEAT_MS);
  localparam int unsigned REP_W = (N_REP < 2) ? 1 : $clog2(N_REP + 1);

  // Only the two arrows repeat; enter always pulses once per press
  for (genvar j = 0; j < 2; j++) begin : g_repeticao
    logic [REP_W-1:0] rep_q;
    logic [REP_W-1:0] rep_d;
    logic             dispara;

    // Count held cycles since the last pulse; clears on press edge and release
    always_comb begin
      rep_d   = '0;
      dispara = 1'b0;
      if (w_nav_press[j] && !nav_ant_q[j]) begin
        if (rep_q == REP_W'(N_REP - 1)) begin
          dispara = 1'b1;
        end else begin
          rep_d = rep_q + REP_W'(1);
        end
      end
    end

    // Repeat counter register
    always_ff @(posedge clock) begin
      if (!reset) begin
        rep_q <= '0;
      end else begin
        rep_q <= rep_d;
      end
    end

    assign w_repete[j] = dispara;
  end
  assign w_repete[2] = 1'b0;
`else
  logic unused_repeat_ms;
  assign unused_repeat_ms = |REPEAT_MS;
  assign w_repete         = '0;
`endif

  // Pulse low on a released-to-pressed transition (or a repeat tick)
  always_comb begin
    pulso_d = ~((w_nav_press & nav_ant_q) | w_repete);
  end

  // Navigation edge history and registered pulses
  always_ff @(posedge clock) begin
    if (!reset) begin
      nav_ant_q <= '1;
      pulso_q   <= '1;
    end else begin
      nav_ant_q <= ~w_nav_press;
      pulso_q   <= pulso_d;
    end
  end

  // Note FSM: latch lowest pressed note, hold it, demand full release
  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q <= OCIOSO;
      codigo_q <= '0;
      idx_q    <= '0;
      valida_q <= 1'b0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (|w_notas) begin
            codigo_q <= w_codigo;
            idx_q    <= w_codigo - CODIGO_W'(1);
            valida_q <= 1'b1;
            estado_q <= TRAVADO;
          end
        end
        TRAVADO: begin
          if (!w_notas[idx_q]) begin
            codigo_q <= '0;
            valida_q <= 1'b0;
            estado_q <= (|w_notas) ? ESPERA_SOLTAR : OCIOSO;
          end
        end
        ESPERA_SOLTAR: begin
          if (!(|w_notas)) estado_q <= OCIOSO;
        end
        default: begin
          estado_q <= OCIOSO;
          codigo_q <= '0;
          valida_q <= 1'b0;
        end
      endcase
    end
  end

  assign botoes_encoded      = codigo_q;
  assign nota_valida         = valida_q;
  assign right_arrow_pressed = pulso_q[0];
  assign left_arrow_pressed  = pulso_q[1];
  assign enter_pressed       = pulso_q[2];
  assign db_estado           = estado_q;

endmodule
`default_nettype wire

// File: tb/tb_interface_botoes.sv
`default_nettype none
// ============================================================================
// Module   : tb_interface_botoes
// Brief    : Directed bench for interface_botoes at CLOCK_FREQ=1000,
//            DEBOUNCE_MS=4 (four-cycle debounce), REPEAT_MS=10.
// Revision : 1.0 - initial release
// ============================================================================
module tb_interface_botoes;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] botoes_n;
  logic        right_n;
  logic        left_n;
  logic        enter_n;
  logic [3:0]  botoes_encoded;
  logic        nota_valida;
  logic        right_arrow_pressed;
  logic        left_arrow_pressed;
  logic        enter_pressed;
  logic [1:0]  db_estado;

  int checks = 0;
  int errors = 0;

  interface_botoes #(
    .CLOCK_FREQ (1000),
    .DEBOUNCE_MS(4),
    .REPEAT_MS  (10)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .botoes_n           (botoes_n),
    .right_n            (right_n),
    .left_n             (left_n),
    .enter_n            (enter_n),
    .botoes_encoded     (botoes_encoded),
    .nota_valida        (nota_valida),
    .right_arrow_pressed(right_arrow_pressed),
    .left_arrow_pressed (left_arrow_pressed),
    .enter_pressed      (enter_pressed),
    .db_estado          (db_estado)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    checks++;
    if (obs !== esp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, esp);
    end
  endtask

  // Advance n rising edges, leaving time 1 unit after the last edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    int n;
    int pos[$];

    // 1: reset with note 3 held
    reset    = 1'b0;
    botoes_n = '1;
    botoes_n[3] = 1'b0;
    right_n  = 1'b1;
    left_n   = 1'b1;
    enter_n  = 1'b1;
    tick(3);
    check("rst_codigo", botoes_encoded, 0);
    check("rst_valida", nota_valida, 0);
    check("rst_pulsos", {enter_pressed, left_arrow_pressed, right_arrow_pressed}, 3'b111);
    check("rst_estado", db_estado, 0);
    reset = 1'b1;
    tick(12);
    check("segurado_pos_reset_codigo", botoes_encoded, 0);
    check("segurado_pos_reset_estado", db_estado, 0);
    botoes_n[3] = 1'b1;
    tick(12);
    botoes_n[3] = 1'b0;
    tick(6);
    check("nota4_antes", botoes_encoded, 0);
    tick(1);
    check("nota4_codigo", botoes_encoded, 4);
    check("nota4_valida", nota_valida, 1);
    botoes_n[3] = 1'b1;
    tick(8);
    check("nota4_solta", botoes_encoded, 0);
    check("nota4_solta_estado", db_estado, 0);

    // 2: enter pulse latency, hold, release and glitch
    enter_n = 1'b0;
    tick(6);
    check("enter_antes", enter_pressed, 1);
    tick(1);
    check("enter_pulso", enter_pressed, 0);
    tick(1);
    check("enter_unico", enter_pressed, 1);
    n = 0;
    repeat (10) begin
      tick(1);
      if (!enter_pressed) n++;
    end
    check("enter_segurado", n, 0);
    enter_n = 1'b1;
    n = 0;
    repeat (10) begin
      tick(1);
      if (!enter_pressed) n++;
    end
    check("enter_soltura", n, 0);
    n = 0;
    for (int t = 0; t < 15; t++) begin
      enter_n = (t < 3) ? 1'b0 : 1'b1;
      tick(1);
      if (!enter_pressed) n++;
    end
    check("enter_glitch", n, 0);

    // 3: latched note ignores others, slide needs full release
    botoes_n[6] = 1'b0;
    tick(7);
    check("nota7_codigo", botoes_encoded, 7);
    check("nota7_valida", nota_valida, 1);
    check("nota7_estado", db_estado, 1);
    botoes_n[2] = 1'b0;
    tick(7);
    check("nota7_mais_2", botoes_encoded, 7);
    botoes_n[6] = 1'b1;
    tick(7);
    check("desliza_codigo", botoes_encoded, 0);
    check("desliza_valida", nota_valida, 0);
    check("desliza_estado", db_estado, 2);
    botoes_n[2] = 1'b1;
    tick(7);
    check("desliza_fim_estado", db_estado, 0);
    check("desliza_fim_codigo", botoes_encoded, 0);

    // 4: simultaneous notes, lowest index wins
    botoes_n[9] = 1'b0;
    botoes_n[4] = 1'b0;
    tick(7);
    check("prioridade_codigo", botoes_encoded, 5);
    botoes_n = '1;
    tick(8);
    check("prioridade_fim", db_estado, 0);

    // 5: right and left together
    right_n = 1'b0;
    left_n  = 1'b0;
    tick(6);
    check("setas_antes", {left_arrow_pressed, right_arrow_pressed}, 2'b11);
    tick(1);
    check("setas_pulso", {left_arrow_pressed, right_arrow_pressed}, 2'b00);
    tick(1);
    check("setas_fim", {left_arrow_pressed, right_arrow_pressed}, 2'b11);
    right_n = 1'b1;
    left_n  = 1'b1;
    tick(10);

    // 6: right held, initial pulse plus optional repeats
    right_n = 1'b0;
    for (int t = 1; t <= 45; t++) begin
      tick(1);
      if (!right_arrow_pressed) pos.push_back(t);
    end
    check("rep_primeiro", (pos.size() > 0) ? pos[0] : 0, 7);
`ifdef AUTO_REPEAT_EN
    check("rep_total", pos.size(), 4);
    for (int i = 1; i < 4; i++) begin
      if (pos.size() > i) check("rep_intervalo", pos[i] - pos[i-1], 10);
    end
`else
    check("rep_total", pos.size(), 1);
`endif
    right_n = 1'b1;
    tick(10);
    check("final_pulsos", {enter_pressed, left_arrow_pressed, right_arrow_pressed}, 3'b111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
